// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: command bytes, FSM states and read dummy-byte count
// shared by the spi_slave_wb bridge.
package spi_slave_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int DUMMY_BYTES = 1;

  typedef enum logic [3:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    WB_WR,
    WB_RD,
    RDUMMY,
    RDATA,
    DROP
  } state_e;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync: 2-FF synchronizers plus edge detect for CSB/SCLK,
// and a matching 2-FF path for MOSI.
module spi_slave_sync (
  input  logic clk,
  input  logic rst,
  input  logic csb,
  input  logic sclk,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csb_fall,
  output logic csb_rise,
  output logic csb_sync,
  output logic mosi_sync
);

  logic [2:0] csb_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;

  // CSB resets high so a held-low pin is seen as a fresh frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      csb_q  <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      csb_q  <= {csb_q[1:0], csb};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign csb_fall  = ~csb_q[1] & csb_q[2];
  assign csb_rise  = csb_q[1] & ~csb_q[2];
  assign csb_sync  = csb_q[1];
  assign mosi_sync = mosi_q[1];

endmodule

// File: rtl/spi_slave_wb.sv
// spi_slave_wb: SPI mode-0 slave driving a Wishbone master port.
// Define SPI_SLAVE_WB_TIMEOUT_EN to enable the Wishbone watchdog.
module spi_slave_wb
  import spi_slave_pkg::*;
#(
  parameter int ADDR_WD = 8,
  parameter int TIMEOUT = 32
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        spi_csb_i,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oeb_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [5:0] DUMMY_BITS = 6'(8 * DUMMY_BYTES);

  logic sclk_rise;
  logic sclk_fall;
  logic csb_fall;
  logic csb_rise;
  logic csb_sync;
  logic mosi_sync;

  state_e state;
  state_e state_nx;

  logic [5:0]         bit_cnt;
  logic [31:0]        rx_q;
  logic [31:0]        rx_nx;
  logic [31:0]        tx_q;
  logic [31:0]        wdata_q;
  logic [ADDR_WD-1:0] addr_q;
  logic [29:0]        addr_ext;
  logic               is_wr;
  logic               abort_q;
  logic               miso_q;
  logic               in_wb;
  logic               tmo;
  logic               ack_ev;
  logic               last8;
  logic               last32;
  logic               dummy_done;

  spi_slave_sync u_sync (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .csb       (spi_csb_i),
    .sclk      (spi_sclk_i),
    .mosi      (spi_mosi_i),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .csb_fall  (csb_fall),
    .csb_rise  (csb_rise),
    .csb_sync  (csb_sync),
    .mosi_sync (mosi_sync)
  );

  assign rx_nx  = {rx_q[30:0], mosi_sync};
  assign in_wb  = (state == WB_WR) || (state == WB_RD);
  assign ack_ev = in_wb && (wbm_ack_i || tmo);
  assign last8  = sclk_rise && (bit_cnt == 6'd7);
  assign last32 = sclk_rise && (bit_cnt == 6'd31);

  // dummy rises keep counting while the read is still in flight
  assign dummy_done = (bit_cnt >= DUMMY_BITS) ||
                      (sclk_rise && (bit_cnt == DUMMY_BITS - 6'd1));

`ifdef SPI_SLAVE_WB_TIMEOUT_EN
  logic [5:0] wd_q;
  logic       err_q;

  assign tmo = in_wb && (wd_q == 6'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wd_q  <= 6'd0;
      err_q <= 1'b0;
    end else begin
      wd_q <= (in_wb && !ack_ev) ? wd_q + 6'd1 : 6'd0;
      if (tmo && !wbm_ack_i) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (csb_fall) state_nx = CMD;
      CMD:    if (last8) state_nx = is_cmd(rx_nx[7:0]) ? ADDR : DROP;
      ADDR:   if (last8) state_nx = is_wr ? WDATA : WB_RD;
      WDATA:  if (last32) state_nx = WB_WR;
      WB_WR: begin
        if (ack_ev) state_nx = (abort_q || csb_rise) ? IDLE : DROP;
      end
      WB_RD: begin
        if (ack_ev) begin
          if (abort_q || csb_rise) state_nx = IDLE;
          else state_nx = dummy_done ? RDATA : RDUMMY;
        end
      end
      RDUMMY: begin
        if (sclk_rise && (bit_cnt == DUMMY_BITS - 6'd1)) state_nx = RDATA;
      end
      RDATA:  if (last32) state_nx = DROP;
      DROP:   state_nx = DROP;
      default: state_nx = IDLE;
    endcase
    if (csb_rise && !in_wb) state_nx = IDLE;
  end

  always_comb begin
    wbm_cyc_o = in_wb;
    wbm_stb_o = in_wb;
    wbm_we_o  = (state == WB_WR);
    wbm_sel_o = in_wb ? 4'hF : 4'h0;
    busy_o    = (state != IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bit_cnt <= 6'd0;
      rx_q    <= 32'd0;
      tx_q    <= 32'd0;
      wdata_q <= 32'd0;
      addr_q  <= '0;
      is_wr   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (state_nx != state && !(state == WB_RD && state_nx == RDUMMY))
        bit_cnt <= 6'd0;
      else if (sclk_rise)
        bit_cnt <= bit_cnt + 6'd1;
      if (sclk_rise && (state == CMD || state == ADDR || state == WDATA))
        rx_q <= rx_nx;
      if (state == CMD && last8) is_wr <= (rx_nx[7:0] == CMD_WRITE);
      if (state == ADDR && last8) addr_q <= ADDR_WD'(rx_nx[7:0]);
      if (state == WDATA && last32) wdata_q <= rx_nx;
      if (state == WB_RD && ack_ev)
        tx_q <= wbm_ack_i ? wbm_dat_i : 32'hFFFF_FFFF;
      else if (state == RDATA && sclk_fall)
        tx_q <= {tx_q[30:0], 1'b0};
      abort_q <= in_wb && (abort_q || csb_rise);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state == IDLE) miso_q <= 1'b0;
    else if (sclk_fall) miso_q <= (state == RDATA) && tx_q[31];
  end

  assign addr_ext       = 30'(addr_q);
  assign wbm_adr_o      = {addr_ext, 2'b00};
  assign wbm_dat_o      = wdata_q;
  assign spi_miso_o     = miso_q;
  assign spi_miso_oeb_o = csb_sync;

endmodule

// File: tb/tb_spi_slave_wb.sv
// tb_spi_slave_wb: directed SPI frames against a frame-level model of
// the bridge, with a Wishbone responder and a per-cycle output checker.
module tb_spi_slave_wb;

  localparam int TIMEOUT = 32;

  typedef logic [7:0] frame_t [8];
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csb = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic        oeb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dato;
  logic [31:0] dati = 32'd0;
  logic        ack = 1'b0;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;

  txn_t        log_q[$];
  int          ack_delay = 3;
  logic [31:0] rd_word = 32'd0;
  int          wcnt = 0;
  logic        cyc_q = 1'b0;

  logic p1 = 1'b1;
  logic p2 = 1'b1;
  logic rst_seen = 1'b0;
  logic err_exp = 1'b0;
  int   hc = 0;

  frame_t f;
  frame_t r;
  int     wk;

  always #5 clk = ~clk;

  spi_slave_wb #(.ADDR_WD(8), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .spi_csb_i      (csb),
    .spi_sclk_i     (sclk),
    .spi_mosi_i     (mosi),
    .spi_miso_o     (miso),
    .spi_miso_oeb_o (oeb),
    .wbm_cyc_o      (cyc),
    .wbm_stb_o      (stb),
    .wbm_we_o       (we),
    .wbm_sel_o      (sel),
    .wbm_adr_o      (adr),
    .wbm_dat_o      (dato),
    .wbm_dat_i      (dati),
    .wbm_ack_i      (ack),
    .busy_o         (busy),
    .err_o          (err)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clks(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  // Wishbone responder: ack after ack_delay cycles (0 = never)
  always @(negedge clk) begin
    if (ack) begin
      ack = 1'b0;
    end else if (cyc && stb) begin
      wcnt++;
      if (ack_delay != 0 && wcnt == ack_delay) begin
        ack  = 1'b1;
        dati = rd_word;
      end
    end else begin
      wcnt = 0;
    end
    if (cyc && !cyc_q) log_q.push_back('{we, adr, dato, sel});
    cyc_q = cyc;
  end

  // per-cycle checks against the model of sync delay, reset and watchdog
  always @(negedge clk) begin
    chk("oeb", oeb, p2);
    chk("err", err, err_exp);
    if (cyc) begin
      chk("stb", stb, 1);
      chk("sel", sel, 4'hF);
      chk("busy_in_cyc", busy, 1);
    end
    if (rst_seen) begin
      chk("rst_cyc", cyc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_miso", miso, 0);
      chk("rst_adr", adr, 0);
      chk("rst_dat", dato, 0);
    end
    rst_seen = rst;
    if (rst) begin
      p1 = 1'b1;
      p2 = 1'b1;
      err_exp = 1'b0;
      hc = 0;
    end else begin
      p2 = p1;
      p1 = csb;
      if (cyc) begin
        hc++;
`ifdef SPI_SLAVE_WB_TIMEOUT_EN
        if (hc > TIMEOUT) chk("cyc_len", hc, TIMEOUT);
        if (hc == TIMEOUT) err_exp = 1'b1;
`endif
      end else begin
        hc = 0;
      end
    end
  end

  task automatic xfer(input frame_t fr, input int n, output frame_t rx);
    for (int i = 0; i < 8; i++) rx[i] = 8'h00;
    csb = 1'b0;
    clks(6);
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        mosi = fr[b][i];
        clks(5);
        rx[b][i] = miso;
        sclk = 1'b1;
        clks(5);
        sclk = 1'b0;
      end
    end
    clks(5);
    csb = 1'b1;
    clks(12);
  endtask

  // frame-level model: which access the frame implies and what MISO shows
  task automatic run_frame(input string tag, input frame_t fr, input int n,
                           input logic [31:0] rd, input int dly,
                           output frame_t rx);
    frame_t      em;
    int          nt;
    logic [31:0] word;
    txn_t        e;
    log_q.delete();
    ack_delay = dly;
    rd_word = rd;
    xfer(fr, n, rx);
    word = (dly == 0) ? 32'hFFFF_FFFF : rd;
    nt = 0;
    e = '0;
    for (int k = 0; k < 8; k++) em[k] = 8'h00;
    if (n >= 2 && fr[0] == 8'h03) begin
      nt = 1;
      e = '{1'b0, {22'd0, fr[1], 2'b00}, 32'd0, 4'hF};
      for (int k = 3; k < 7; k++) em[k] = word[8*(6-k) +: 8];
    end
    if (n >= 6 && fr[0] == 8'h02) begin
      nt = 1;
      e = '{1'b1, {22'd0, fr[1], 2'b00}, {fr[2], fr[3], fr[4], fr[5]}, 4'hF};
    end
    chk({tag, "_ncyc"}, log_q.size(), nt);
    if (nt == 1 && log_q.size() == 1) begin
      chk({tag, "_adr"}, log_q[0].adr, e.adr);
      chk({tag, "_we"}, log_q[0].we, e.we);
      chk({tag, "_sel"}, log_q[0].sel, e.sel);
      if (e.we) chk({tag, "_dat"}, log_q[0].dat, e.dat);
    end
    for (int k = 0; k < n; k++)
      chk($sformatf("%s_miso%0d", tag, k), rx[k], em[k]);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    clks(3);
    rst = 1'b0;
    clks(3);
    chk("init_cyc", cyc, 0);
    chk("init_we", we, 0);
    chk("init_sel", sel, 0);
    chk("init_adr", adr, 0);
    chk("init_oeb", oeb, 1);
    chk("init_busy", busy, 0);
    chk("init_err", err, 0);

    f = '{8'h02, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00};
    run_frame("wr", f, 6, 32'd0, 3, r);
    chk("wr_lit_adr", (log_q.size() > 0) ? log_q[0].adr : 32'hX, 32'h40);
    chk("wr_lit_dat", (log_q.size() > 0) ? log_q[0].dat : 32'hX, 32'hDEADBEEF);

    f = '{8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("rd", f, 7, 32'h12345678, 3, r);
    chk("rd_lit_adr", (log_q.size() > 0) ? log_q[0].adr : 32'hX, 32'h14);
    chk("rd_lit_b3", r[3], 8'h12);
    chk("rd_lit_b6", r[6], 8'h78);

    f = '{8'h02, 8'h10, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("short", f, 4, 32'd0, 3, r);
    f = '{8'h02, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    run_frame("after", f, 6, 32'd0, 3, r);
    chk("after_lit_adr", (log_q.size() > 0) ? log_q[0].adr : 32'hX, 32'h4);

    f = '{8'h7F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00};
    run_frame("bad", f, 5, 32'd0, 3, r);
    chk("bad_err", err, 0);

`ifdef SPI_SLAVE_WB_TIMEOUT_EN
    f = '{8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("tmo", f, 7, 32'd0, 0, r);
    chk("tmo_err", err, 1);
    chk("tmo_lit_b4", r[4], 8'hFF);
`endif

    f = '{8'h03, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    log_q.delete();
    ack_delay = 0;
    fork
      xfer(f, 7, r);
      begin
        wk = 0;
        while (!cyc && wk < 600) begin
          clks(1);
          wk++;
        end
        chk("rrst_cyc_seen", cyc, 1);
        clks(2);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        chk("rrst_cyc", cyc, 0);
        chk("rrst_busy", busy, 0);
        chk("rrst_oeb", oeb, 1);
        chk("rrst_err", err, 0);
      end
    join
    chk("rrst_ncyc", log_q.size(), 1);

    f = '{8'h02, 8'h22, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h00, 8'h00};
    run_frame("post", f, 6, 32'd0, 2, r);
    chk("post_lit_dat", (log_q.size() > 0) ? log_q[0].dat : 32'hX, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
